// File: rtl/dummy_coproc_engine.sv
// Coprocessor engine: routes each request to a COMB, PIPE or ITER path and returns results in order.
// Optional performance counters are built only when DUMMY_COPROC_PERF_EN is defined.
//
// state  | meaning
// S_IDLE | accepting any mode; COMB/reserved results load the output register directly
// S_PIPE | PIPE ops in flight; only further PIPE requests are accepted
// S_ITER | shift-add multiply in progress; no requests accepted
module dummy_coproc_engine #(
    parameter int WIDTH      = 32,
    parameter int PIPE_DEPTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             err_o,
    output logic [31:0]      perf_ops_o,
    output logic [31:0]      perf_stall_o
);

    typedef enum logic [1:0] {S_IDLE, S_PIPE, S_ITER} state_e;

    localparam logic [1:0] MODE_COMB = 2'd0;
    localparam logic [1:0] MODE_PIPE = 2'd1;
    localparam logic [1:0] MODE_ITER = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    localparam bit HAS_STAGES = (PIPE_DEPTH > 1);
    localparam int NS         = HAS_STAGES ? PIPE_DEPTH - 1 : 1;
    localparam int OCC_W      = $clog2(PIPE_DEPTH + 1);
    localparam int CNT_W      = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               out_err_q;

    logic               stall, out_free, ready, accept;
    logic               direct_accept, pipe_accept, iter_accept;
    logic               pipe_load, iter_load;
    logic               load, load_err;
    logic [WIDTH-1:0]   load_data;

    logic [NS-1:0]      stg_v_q;
    logic [WIDTH-1:0]   stg_d_q [NS];
    logic [OCC_W-1:0]   occ_q, occ_d;

    logic [WIDTH-1:0]   it_a_q, it_b_q, acc_q, acc_sum, iter_result;
    logic [CNT_W-1:0]   cnt_q;

    assign stall    = out_valid_q && !ready_i;
    assign out_free = !stall;

    // Non-PIPE requests wait in S_PIPE so completions stay in order.
    assign ready  = !stall && ((state_q == S_IDLE) ||
                               (state_q == S_PIPE && mode_i == MODE_PIPE));
    assign accept = valid_i && ready;

    assign pipe_accept   = accept && (mode_i == MODE_PIPE) && HAS_STAGES;
    assign iter_accept   = accept && (state_q == S_IDLE) && (mode_i == MODE_ITER);
    assign direct_accept = accept && (state_q == S_IDLE) &&
                           ((mode_i == MODE_COMB) || (mode_i == MODE_RSVD) ||
                            (mode_i == MODE_PIPE && !HAS_STAGES));

    assign pipe_load = stg_v_q[NS-1] && !stall;
    assign iter_load = (state_q == S_ITER) && (cnt_q <= CNT_W'(1)) && out_free;

    // FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (pipe_accept) begin
                    state_d = S_PIPE;
                end else if (iter_accept) begin
                    state_d = S_ITER;
                end
            end
            S_PIPE: begin
                if (occ_q == '0 && !pipe_accept) begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                if (iter_load) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // PIPE stages: the output register is the last of PIPE_DEPTH stages.
    generate
        if (HAS_STAGES) begin : g_stages
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    stg_v_q <= '0;
                    for (int k = 0; k < NS; k++) begin
                        stg_d_q[k] <= '0;
                    end
                end else if (!stall) begin
                    stg_v_q[0] <= pipe_accept;
                    stg_d_q[0] <= a_i - b_i;
                    for (int k = 1; k < NS; k++) begin
                        stg_v_q[k] <= stg_v_q[k-1];
                        stg_d_q[k] <= stg_d_q[k-1];
                    end
                end
            end
        end else begin : g_no_stages
            assign stg_v_q    = '0;
            assign stg_d_q[0] = '0;
        end
    endgenerate

    always_comb begin
        occ_d = occ_q;
        case ({pipe_accept, pipe_load})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // ITER: one multiplier bit per cycle; the final sum is loaded on the last step when possible.
    assign acc_sum     = acc_q + (it_b_q[0] ? it_a_q : '0);
    assign iter_result = (cnt_q == '0) ? acc_q : acc_sum;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            it_a_q <= '0;
            it_b_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else if (iter_accept) begin
            it_a_q <= a_i;
            it_b_q <= b_i;
            acc_q  <= '0;
            cnt_q  <= CNT_W'(WIDTH);
        end else if (state_q == S_ITER && cnt_q != '0) begin
            acc_q  <= acc_sum;
            it_a_q <= it_a_q << 1;
            it_b_q <= it_b_q >> 1;
            cnt_q  <= cnt_q - CNT_W'(1);
        end
    end

    // Output register source select; at most one source is active per cycle.
    always_comb begin
        load      = 1'b0;
        load_data = '0;
        load_err  = 1'b0;
        if (direct_accept) begin
            load     = 1'b1;
            load_err = (mode_i == MODE_RSVD);
            case (mode_i)
                MODE_COMB: load_data = a_i + b_i;
                MODE_PIPE: load_data = a_i - b_i;
                default:   load_data = '0;
            endcase
        end else if (pipe_load) begin
            load      = 1'b1;
            load_data = stg_d_q[NS-1];
        end else if (iter_load) begin
            load      = 1'b1;
            load_data = iter_result;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else if (out_free) begin
            out_valid_q <= load;
            out_err_q   <= load && load_err;
            if (load) begin
                out_data_q <= load_data;
            end
        end
    end

    assign ready_o  = ready;
    assign valid_o  = out_valid_q;
    assign result_o = out_data_q;
    assign err_o    = out_err_q;

`ifdef DUMMY_COPROC_PERF_EN
    logic [31:0] perf_ops_q, perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (out_valid_q && ready_i && perf_ops_q != '1) begin
                perf_ops_q <= perf_ops_q + 32'd1;
            end
            if (stall && perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_ops_o   = perf_ops_q;
    assign perf_stall_o = perf_stall_q;
`else
    assign perf_ops_o   = '0;
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_dummy_coproc_engine.sv
// Directed bench for dummy_coproc_engine at WIDTH=8, PIPE_DEPTH=3.
// Perf counter expectations follow whether DUMMY_COPROC_PERF_EN is defined.
module tb_dummy_coproc_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        ready_o;
    logic [1:0]  mode;
    logic [7:0]  a, b;
    logic        valid_o;
    logic        rdy;
    logic [7:0]  result_o;
    logic        err_o;
    logic [31:0] perf_ops_o, perf_stall_o;

    int n_chk = 0;
    int n_err = 0;

    dummy_coproc_engine #(.WIDTH(8), .PIPE_DEPTH(3)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .valid_i      (valid),
        .ready_o      (ready_o),
        .mode_i       (mode),
        .a_i          (a),
        .b_i          (b),
        .valid_o      (valid_o),
        .ready_i      (rdy),
        .result_o     (result_o),
        .err_o        (err_o),
        .perf_ops_o   (perf_ops_o),
        .perf_stall_o (perf_stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] av, input logic [7:0] bv);
        valid = v;
        mode  = m;
        a     = av;
        b     = bv;
    endtask

    task automatic run_iter(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] exp);
        drive(1'b1, 2'd2, av, bv);
        #1;
        chk("iter_accept_rdy", ready_o, 1);
        cyc();
        valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk("iter_busy_rdy", ready_o, 0);
            chk("iter_busy_vld", valid_o, 0);
            cyc();
        end
        #1;
        chk("iter_vld", valid_o, 1);
        chk("iter_res", result_o, exp);
        chk("iter_err", err_o, 0);
        cyc();
    endtask

    logic [7:0] pa [4], pb [4], pr [4];
    logic [7:0] ba [3], bb [3], br [3];
    logic [7:0] ord_res [2];
    int got, saw;
    bit accepted;

    initial begin
        pa = '{8'h10, 8'h05, 8'hFF, 8'h00};
        pb = '{8'h20, 8'h01, 8'hFF, 8'h01};
        pr = '{8'hF0, 8'h04, 8'h00, 8'hFF};
        ba = '{8'h09, 8'h40, 8'h02};
        bb = '{8'h03, 8'h01, 8'h05};
        br = '{8'h06, 8'h3F, 8'hFD};

        rst_n = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", valid_o, 0);
        chk("rst_res", result_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rdy", ready_o, 1);
        chk("rst_perf_ops", perf_ops_o, 0);
        chk("rst_perf_stall", perf_stall_o, 0);
        rst_n = 1'b1;
        cyc();

        // COMB
        drive(1'b1, 2'd0, 8'h12, 8'h34);
        #1;
        chk("comb_rdy", ready_o, 1);
        chk("comb_lat", valid_o, 0);
        cyc();
        valid = 1'b0;
        #1;
        chk("comb_vld", valid_o, 1);
        chk("comb_res", result_o, 8'h46);
        chk("comb_err", err_o, 0);
        cyc();
        #1;
        chk("comb_drop", valid_o, 0);
        cyc();

        // PIPE burst: results in cycles t+3..t+6
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(1'b1, 2'd1, pa[i], pb[i]);
            else valid = 1'b0;
            #1;
            if (i < 4) chk("pipe_rdy", ready_o, 1);
            if (i >= 3) begin
                chk("pipe_vld", valid_o, 1);
                chk("pipe_res", result_o, pr[i-3]);
            end else begin
                chk("pipe_lat", valid_o, 0);
            end
            cyc();
        end
        #1;
        chk("pipe_drain", valid_o, 0);
        cyc();

        // ITER
        run_iter(8'd13, 8'd11, 8'h8F);
        run_iter(8'h80, 8'h02, 8'h00);

        // Ordering: COMB behind an in-flight PIPE op
        drive(1'b1, 2'd1, 8'h30, 8'h10);
        #1;
        chk("ord_pipe_rdy", ready_o, 1);
        cyc();
        drive(1'b1, 2'd0, 8'h01, 8'h02);
        got = 0;
        accepted = 1'b0;
        ord_res = '{8'h00, 8'h00};
        for (int i = 0; i < 12; i++) begin
            #1;
            if (valid_o && got < 2) begin
                ord_res[got] = result_o;
                got++;
            end
            if (!accepted && ready_o) begin
                chk("ord_wait_drain", got, 1);
                accepted = 1'b1;
            end
            cyc();
            if (accepted) valid = 1'b0;
        end
        chk("ord_accepted", accepted, 1);
        chk("ord_count", got, 2);
        chk("ord_first", ord_res[0], 8'h20);
        chk("ord_second", ord_res[1], 8'h03);

        // Backpressure during a 3-op PIPE burst
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd1, ba[i], bb[i]);
            #1;
            chk("bp_accept_rdy", ready_o, 1);
            cyc();
        end
        valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold_vld", valid_o, 1);
            chk("bp_hold_res", result_o, 8'h06);
            chk("bp_hold_rdy", ready_o, 0);
            cyc();
        end
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_drain_vld", valid_o, 1);
            chk("bp_drain_res", result_o, br[i]);
            cyc();
        end
        #1;
        chk("bp_empty", valid_o, 0);
`ifdef DUMMY_COPROC_PERF_EN
        chk("perf_ops", perf_ops_o, 12);
        chk("perf_stall", perf_stall_o, 5);
`else
        chk("perf_ops_tied", perf_ops_o, 0);
        chk("perf_stall_tied", perf_stall_o, 0);
`endif
        cyc();

        // Reserved mode
        drive(1'b1, 2'd3, 8'h55, 8'hAA);
        #1;
        chk("err_rdy", ready_o, 1);
        cyc();
        valid = 1'b0;
        #1;
        chk("err_vld", valid_o, 1);
        chk("err_res", result_o, 0);
        chk("err_flag", err_o, 1);
        cyc();
        #1;
        chk("err_clear", err_o, 0);
        chk("err_drop", valid_o, 0);
        cyc();

        // Asynchronous reset while a result is held
        rdy = 1'b0;
        drive(1'b1, 2'd0, 8'h0F, 8'h01);
        cyc();
        valid = 1'b0;
        #1;
        chk("arst_pre_vld", valid_o, 1);
        chk("arst_pre_res", result_o, 8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", valid_o, 0);
        chk("arst_res", result_o, 0);
        cyc();
        rst_n = 1'b1;
        rdy = 1'b1;
        cyc();

        // Reset mid-ITER
        drive(1'b1, 2'd2, 8'h07, 8'h03);
        #1;
        chk("riter_rdy", ready_o, 1);
        cyc();
        valid = 1'b0;
        repeat (3) cyc();
        #1;
        chk("riter_busy", ready_o, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("riter_vld", valid_o, 0);
        chk("riter_rdy_now", ready_o, 1);
        cyc();
        cyc();
        rst_n = 1'b1;
        saw = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (valid_o) saw++;
            cyc();
        end
        chk("riter_no_result", saw, 0);
        #1;
        chk("riter_idle_rdy", ready_o, 1);
        chk("riter_perf_ops", perf_ops_o, 0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
